// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding selects,
// divide FSM state encoding and the divide counter width helper.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // The counter is loaded with cycles-2, so it only has to hold values below cycles-1.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles <= 3) ? 1 : $clog2(cycles - 1);
    endfunction

endpackage

// File: rtl/div_stall_fsm.sv
// Multi-cycle divide sequencer: freezes F/D/E for DIV_CYCLES cycles per divide,
// then pulses div_done for the single cycle in which E advances.
module div_stall_fsm
    import hazard_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic divE,
    output logic divstall,
    output logic div_busy,
    output logic div_done
);

    localparam int unsigned CW = cnt_width(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 2);

    div_state_t    state, state_next;
    logic [CW-1:0] cnt, cnt_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // divE is still asserted in DONE; only IDLE may start a new divide.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (divE) begin
                    state_next = BUSY;
                    cnt_next   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        divstall = (state == BUSY) || ((state == IDLE) && divE);
        div_busy = (state == BUSY);
        div_done = (state == DONE);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: forwarding selects,
// load-use / branch / divide stalls and flushes. HAZARD_PERF_EN adds cycle counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned REG_W      = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic [REG_W-1:0] rsE,
    input  logic [REG_W-1:0] rtE,
    input  logic [REG_W-1:0] writeregE,
    input  logic [REG_W-1:0] writeregM,
    input  logic [REG_W-1:0] writeregW,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             memtoregE,
    input  logic             memtoregM,
    input  logic             branchD,
    input  logic             pcsrcD,
    input  logic             divE,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             div_busy,
    output logic             div_done,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_cycles
);

    logic divstall;
    logic lwstall;
    logic brstall;

    div_stall_fsm #(.DIV_CYCLES(DIV_CYCLES)) u_div_fsm (
        .clk      (clk),
        .reset    (reset),
        .divE     (divE),
        .divstall (divstall),
        .div_busy (div_busy),
        .div_done (div_done)
    );

    // M result takes priority over W; register 0 is never forwarded.
    always_comb begin
        forwardAE = FWD_RF;
        if ((rsE != '0) && regwriteM && (writeregM == rsE))      forwardAE = FWD_M;
        else if ((rsE != '0) && regwriteW && (writeregW == rsE)) forwardAE = FWD_W;

        forwardBE = FWD_RF;
        if ((rtE != '0) && regwriteM && (writeregM == rtE))      forwardBE = FWD_M;
        else if ((rtE != '0) && regwriteW && (writeregW == rtE)) forwardBE = FWD_W;

        forwardAD = (rsD != '0) && regwriteM && (writeregM == rsD);
        forwardBD = (rtD != '0) && regwriteM && (writeregM == rtD);
    end

    // A divide freezes E, so it must not also be flushed; M takes the bubble instead.
    always_comb begin
        lwstall = memtoregE && ((rtE == rsD) || (rtE == rtD));
        brstall = branchD &&
                  ((regwriteE && ((writeregE == rsD) || (writeregE == rtD))) ||
                   (memtoregM && ((writeregM == rsD) || (writeregM == rtD))));
        stallF  = lwstall || brstall || divstall;
        stallD  = stallF;
        stallE  = divstall;
        flushE  = (lwstall || brstall) && !divstall;
        flushM  = divstall;
        flushD  = pcsrcD && !stallD;
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (stallF)           stall_cycles <= stall_cycles + 32'd1;
            if (flushE || flushD) flush_cycles <= flush_cycles + 32'd1;
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed cases with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_hazard_ctrl;

    localparam int unsigned N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic       branchD, pcsrcD, divE;
    logic       stallF, stallD, stallE, flushD, flushE, flushM;
    logic       forwardAD, forwardBD, div_busy, div_done;
    logic [1:0] forwardAE, forwardBE;
    logic [31:0] stall_cycles, flush_cycles;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    // Model state: whether a divide occupies E, how many stall cycles it has had,
    // and whether this is the release (done) cycle.
    bit          m_in_div = 1'b0;
    int          m_k      = 0;
    bit          m_done   = 1'b0;
    bit [31:0]   m_stall_cnt = '0;
    bit [31:0]   m_flush_cnt = '0;

    hazard_ctrl #(.DIV_CYCLES(N), .REG_W(5)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .pcsrcD(pcsrcD), .divE(divE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .div_busy(div_busy), .div_done(div_done),
        .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_fwdE(input logic [4:0] src);
        if (src != 0 && regwriteM && writeregM == src) return 2;
        if (src != 0 && regwriteW && writeregW == src) return 1;
        return 0;
    endfunction

    function automatic int m_fwdD(input logic [4:0] src);
        return (src != 0 && regwriteM && writeregM == src) ? 1 : 0;
    endfunction

    function automatic bit m_divstall();
        if (m_done)   return 1'b0;
        if (m_in_div) return 1'b1;
        return divE;
    endfunction

    function automatic bit m_hazard();
        bit lw, br;
        lw = memtoregE && (rtE == rsD || rtE == rtD);
        br = branchD && ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                         (memtoregM && (writeregM == rsD || writeregM == rtD)));
        return lw || br;
    endfunction

    function automatic bit m_stall();
        return m_hazard() || m_divstall();
    endfunction

    function automatic bit m_flushE();
        return m_hazard() && !m_divstall();
    endfunction

    function automatic bit m_flushD();
        return pcsrcD && !m_stall();
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_in_div = 1'b0; m_k = 0; m_done = 1'b0;
            m_stall_cnt = '0; m_flush_cnt = '0;
        end else begin
            if (m_stall())                m_stall_cnt = m_stall_cnt + 1;
            if (m_flushE() || m_flushD()) m_flush_cnt = m_flush_cnt + 1;
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_in_div) begin
                m_k = m_k + 1;
                if (m_k == N) begin
                    m_in_div = 1'b0;
                    m_done   = 1'b1;
                end
            end else if (divE) begin
                m_in_div = 1'b1;
                m_k      = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("forwardAE", int'(forwardAE), m_fwdE(rsE));
            chk("forwardBE", int'(forwardBE), m_fwdE(rtE));
            chk("forwardAD", int'(forwardAD), m_fwdD(rsD));
            chk("forwardBD", int'(forwardBD), m_fwdD(rtD));
            chk("stallF", int'(stallF), int'(m_stall()));
            chk("stallD", int'(stallD), int'(m_stall()));
            chk("stallE", int'(stallE), int'(m_divstall()));
            chk("flushE", int'(flushE), int'(m_flushE()));
            chk("flushM", int'(flushM), int'(m_divstall()));
            chk("flushD", int'(flushD), int'(m_flushD()));
            chk("div_busy", int'(div_busy), int'(m_in_div && !m_done));
            chk("div_done", int'(div_done), int'(m_done));
`ifdef HAZARD_PERF_EN
            chk("stall_cycles", int'(stall_cycles), int'(m_stall_cnt));
            chk("flush_cycles", int'(flush_cycles), int'(m_flush_cnt));
`else
            chk("stall_cycles", int'(stall_cycles), 0);
            chk("flush_cycles", int'(flush_cycles), 0);
`endif
        end
    end

    task automatic quiet();
        rsD = '0; rtD = '0; rsE = '0; rtE = '0;
        writeregE = '0; writeregM = '0; writeregW = '0;
        regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
        memtoregE = 1'b0; memtoregM = 1'b0;
        branchD = 1'b0; pcsrcD = 1'b0; divE = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        int ns, nd;
        quiet();
        reset = 1'b1;
        step();
        check_en = 1'b1;
        step();
        @(negedge clk);
        chk("reset_busy", int'(div_busy), 0);
        chk("reset_done", int'(div_done), 0);
        chk("reset_stallE", int'(stallE), 0);
        chk("reset_stall_cycles", int'(stall_cycles), 0);
        step();
        reset = 1'b0;

        // Forwarding priority
        regwriteM = 1'b1; writeregM = 5'd8; regwriteW = 1'b1; writeregW = 5'd8; rsE = 5'd8;
        @(negedge clk); chk("fwd_M_prio", int'(forwardAE), 2);
        regwriteM = 1'b0;
        @(negedge clk); chk("fwd_W", int'(forwardAE), 1);
        rsE = 5'd0;
        @(negedge clk); chk("fwd_r0", int'(forwardAE), 0);
        step(); quiet();

        // Load-use
        memtoregE = 1'b1; rtE = 5'd9; rsD = 5'd9;
        @(negedge clk);
        chk("lw_stallF", int'(stallF), 1);
        chk("lw_stallD", int'(stallD), 1);
        chk("lw_flushE", int'(flushE), 1);
        chk("lw_stallE", int'(stallE), 0);
        chk("lw_flushM", int'(flushM), 0);
        step(); quiet();

        // Branch hazard, then taken branch with no hazard
        branchD = 1'b1; regwriteE = 1'b1; writeregE = 5'd4; rtD = 5'd4;
        @(negedge clk);
        chk("br_stallD", int'(stallD), 1);
        chk("br_flushE", int'(flushE), 1);
        step(); quiet();
        pcsrcD = 1'b1;
        @(negedge clk);
        chk("pc_flushD", int'(flushD), 1);
        chk("pc_stallD", int'(stallD), 0);
        step(); quiet();

        // Single divide held high: N freeze cycles then the done cycle
        divE = 1'b1;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk("div_stallE", int'(stallE), 1);
            chk("div_stallF", int'(stallF), 1);
            chk("div_flushM", int'(flushM), 1);
            @(posedge clk);
        end
        @(negedge clk);
        chk("div_done_pulse", int'(div_done), 1);
        chk("div_done_nostall", int'(stallF), 0);
        divE = 1'b0;
        @(negedge clk);
        chk("div_no_retrigger", int'(stallE), 0);
        chk("div_done_low", int'(div_done), 0);

        // Reset on the second BUSY cycle
        step(); divE = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1; divE = 1'b0;
        @(negedge clk);
        chk("mid_busy_before", int'(div_busy), 1);
        step(); reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", int'(div_busy), 0);
        chk("rst_mid_stallE", int'(stallE), 0);
        chk("rst_mid_stallF", int'(stallF), 0);

        // Back-to-back divides
        step(); reset = 1'b1;
        step(); reset = 1'b0; divE = 1'b1;
        ns = 0; nd = 0;
        for (int i = 0; i < 2 * (N + 1); i++) begin
            @(negedge clk);
            ns += int'(stallF);
            nd += int'(div_done);
        end
        divE = 1'b0;
        chk("b2b_stalls", ns, 2 * N);
        chk("b2b_dones", nd, 2);
        @(posedge clk); @(negedge clk);
`ifdef HAZARD_PERF_EN
        chk("b2b_stall_cycles", int'(stall_cycles), 8);
`else
        chk("b2b_stall_cycles", int'(stall_cycles), 0);
`endif

        // Randomized traffic; small register range to make matches frequent
        for (int c = 0; c < 800; c++) begin
            step();
            rsD = 5'($urandom_range(0, 3));  rtD = 5'($urandom_range(0, 3));
            rsE = 5'($urandom_range(0, 3));  rtE = 5'($urandom_range(0, 3));
            writeregE = 5'($urandom_range(0, 3));
            writeregM = 5'($urandom_range(0, 3));
            writeregW = 5'($urandom_range(0, 3));
            regwriteE = 1'($urandom_range(0, 1));
            regwriteM = 1'($urandom_range(0, 1));
            regwriteW = 1'($urandom_range(0, 1));
            memtoregE = ($urandom_range(0, 3) == 0);
            memtoregM = ($urandom_range(0, 3) == 0);
            branchD   = ($urandom_range(0, 2) == 0);
            pcsrcD    = ($urandom_range(0, 2) == 0);
            divE      = ($urandom_range(0, 5) == 0);
            reset     = ($urandom_range(0, 59) == 0);
        end
        step(); quiet(); reset = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        check_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
